fetch_stage: RTL

- Instruction-fetch stage of the pipelined RV32I core, with the IF/ID pipeline register built in.
- Holds PCF and issues instruction-memory requests over a req/gnt/rvalid handshake with at most one request outstanding.
- Applies StallF, StallD, FlushD and PCSrcE/PCTargetE from the hazard unit and execute stage.
- Delivers InstrD, PCD, PCPlus4D and ValidD to decode. When memory has not returned an instruction, it inserts bubbles instead of requesting a pipeline stall.

---
 rtl/fetch_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with built-in IF/ID register.
// One outstanding imem request; bubbles are inserted while memory is slow.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] PCF;
  logic [31:0] holdInstr;
  logic [31:0] holdPC;
  logic        load;
  logic [31:0] ldInstr;
  logic [31:0] ldPC;

  assign imem_req  = !rst && state == REQ && !StallF && !PCSrcE;
  assign imem_addr = PCF & 32'hFFFF_FFFC;

  // Instruction handed to decode this cycle, if any
  always_comb begin
    load    = 1'b0;
    ldInstr = imem_rdata;
    ldPC    = PCF;
    if (!PCSrcE && !StallD) begin
      unique case (1'b1)
        state == WAIT && imem_rvalid: load = 1'b1;
        state == HOLD: begin
          load    = 1'b1;
          ldInstr = holdInstr;
          ldPC    = holdPC;
        end
        default: load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= REQ;
      PCF       <= RESET_PC;
      holdInstr <= NOP_INSTR;
      holdPC    <= 32'h0;
    end else if (PCSrcE) begin
      PCF <= PCTargetE & 32'hFFFF_FFFC;
      unique case (state)
        WAIT:    state <= imem_rvalid ? REQ : DROP;
        DROP:    state <= imem_rvalid ? REQ : DROP;
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        REQ: if (imem_req && imem_gnt) state <= WAIT;
        WAIT: if (imem_rvalid) begin
          PCF <= PCF + 32'd4;
          if (StallD) begin
            holdInstr <= imem_rdata;
            holdPC    <= PCF;
            state     <= HOLD;
          end else begin
            state <= REQ;
          end
        end
        HOLD: if (!StallD) state <= REQ;
        DROP: if (imem_rvalid) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (load) begin
        InstrD   <= ldInstr;
        PCD      <= ldPC;
        PCPlus4D <= ldPC + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule
